synapse_current: RTL and testbench

//  Upstream stage of the lif node. Converts N_IN presynaptic spike lines into the unsigned

---
 rtl/synapse_pkg.sv | 30 +++
 rtl/syn_weight_bank.sv | 55 +++++
 rtl/synapse_current.sv | 143 ++++++++++++++
 tb/tb_synapse_current.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/synapse_pkg.sv
// Shared types and config-byte field positions for the synapse_current block.
// Weights are 5-bit two's complement, built from a sign/magnitude config byte.
package synapse_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COMMIT = 2'd1,
        RUN    = 2'd2
    } state_e;

    localparam int ADDR_MSB = 7;
    localparam int ADDR_LSB = 5;
    localparam int ADDR_W   = ADDR_MSB - ADDR_LSB + 1;
    localparam int INH_BIT  = 4;
    localparam int MAG_MSB  = 3;
    localparam int MAG_LSB  = 0;
    localparam int W_WIDTH  = 5;

    // Sign/magnitude config byte to two's complement weight.
    function automatic logic [W_WIDTH-1:0] cfg_weight(input logic [7:0] b);
        logic [W_WIDTH-1:0] mag;
        mag = {1'b0, b[MAG_MSB:MAG_LSB]};
        if (b[INH_BIT]) begin
            return (~mag) + {{(W_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            return mag;
        end
    endfunction

endpackage

// File: rtl/syn_weight_bank.sv
// Double-buffered weight store: beats land in the shadow bank, a commit strobe
// copies the whole shadow bank into the active bank used for integration.
module syn_weight_bank
    import synapse_pkg::*;
#(
    parameter int N_IN = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [W_WIDTH-1:0]        wr_weight,
    input  logic                      commit,
    output logic [N_IN*W_WIDTH-1:0]   active_flat
);

    logic [W_WIDTH-1:0] shadow_q [N_IN];
    logic [W_WIDTH-1:0] shadow_d [N_IN];
    logic [W_WIDTH-1:0] active_q [N_IN];
    logic [W_WIDTH-1:0] active_d [N_IN];

    // Next-state of both banks; addresses outside 0..N_IN-1 match no entry and are dropped.
    always_comb begin
        active_flat = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (wr_en && (wr_addr == ADDR_W'(i))) begin
                shadow_d[i] = wr_weight;
            end else begin
                shadow_d[i] = shadow_q[i];
            end
            if (commit) begin
                active_d[i] = shadow_q[i];
            end else begin
                active_d[i] = active_q[i];
            end
            active_flat[i*W_WIDTH +: W_WIDTH] = active_q[i];
        end
    end

    // Bank registers, cleared by reset so a partial load never survives it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_IN; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
        end
    end

endmodule

// File: rtl/synapse_current.sv
// Spike-to-current stage: weighted spike sum, shift leak, clamp to unsigned range.
// Optional feature macro: SYN_POSTSPIKE_RESET_EN (post_spike clears the current).
module synapse_current
    import synapse_pkg::*;
#(
    parameter int N_IN        = 8,
    parameter int CUR_WIDTH   = 8,
    parameter int DECAY_SHIFT = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [N_IN-1:0]      spike_in,
    input  logic                 post_spike,
    input  logic                 cfg_valid,
    input  logic [7:0]           cfg_data,
    input  logic                 cfg_last,
    output logic                 cfg_ready,
    output logic [CUR_WIDTH-1:0] current,
    output logic                 sat,
    output logic                 running
);

    localparam int SUM_W = CUR_WIDTH + 3;
    localparam logic signed [SUM_W-1:0] CUR_MAX = SUM_W'((1 << CUR_WIDTH) - 1);

    state_e                   state_q, state_d;
    logic                     cfg_ready_q, cfg_ready_d;
    logic                     running_q, running_d;
    logic [CUR_WIDTH-1:0]     current_q, current_d;
    logic                     sat_q, sat_d;

    logic                     accept_s;
    logic                     integrating_s;
    logic [N_IN*W_WIDTH-1:0]  active_flat_s;
    logic signed [SUM_W-1:0]  sum_s;
    logic signed [SUM_W-1:0]  nxt_s;
    logic [CUR_WIDTH-1:0]     clamp_s;
    logic                     clamp_hi_s;

    assign accept_s      = cfg_valid & cfg_ready_q;
    assign integrating_s = ena & (state_q != IDLE);

    syn_weight_bank #(
        .N_IN (N_IN)
    ) u_bank (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (accept_s),
        .wr_addr     (cfg_data[ADDR_MSB:ADDR_LSB]),
        .wr_weight   (cfg_weight(cfg_data)),
        .commit      (state_q == COMMIT),
        .active_flat (active_flat_s)
    );

`ifndef SYN_POSTSPIKE_RESET_EN
    logic unused_post_spike;
    assign unused_post_spike = post_spike;
`endif

    // Sequencer: a cfg_last beat schedules a one-cycle commit, then RUN.
    always_comb begin
        case (state_q)
            IDLE:    state_d = (accept_s && cfg_last) ? COMMIT : IDLE;
            COMMIT:  state_d = RUN;
            RUN:     state_d = (accept_s && cfg_last) ? COMMIT : RUN;
            default: state_d = IDLE;
        endcase
        cfg_ready_d = (state_d != COMMIT);
        running_d   = (state_d != IDLE);
    end

    // Signed weighted sum of the spiking lines.
    always_comb begin
        sum_s = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (spike_in[i]) begin
                sum_s = sum_s + SUM_W'($signed(active_flat_s[i*W_WIDTH +: W_WIDTH]));
            end else begin
                sum_s = sum_s;
            end
        end
    end

    // Leak, add, clamp; the low clamp is silent, only the high clamp flags sat.
    always_comb begin
        nxt_s = $signed({3'b000, current_q})
              - $signed({3'b000, current_q >> DECAY_SHIFT})
              + sum_s;
        if (nxt_s[SUM_W-1]) begin
            clamp_s    = '0;
            clamp_hi_s = 1'b0;
        end else if (nxt_s > CUR_MAX) begin
            clamp_s    = {CUR_WIDTH{1'b1}};
            clamp_hi_s = 1'b1;
        end else begin
            clamp_s    = nxt_s[CUR_WIDTH-1:0];
            clamp_hi_s = 1'b0;
        end
    end

    // Output current selection.
    always_comb begin
        if (state_q == IDLE) begin
            current_d = '0;
            sat_d     = 1'b0;
        end else if (!integrating_s) begin
            current_d = current_q;
            sat_d     = 1'b0;
`ifdef SYN_POSTSPIKE_RESET_EN
        end else if (post_spike) begin
            current_d = '0;
            sat_d     = 1'b0;
`endif
        end else begin
            current_d = clamp_s;
            sat_d     = clamp_hi_s;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cfg_ready_q <= 1'b1;
            running_q   <= 1'b0;
            current_q   <= '0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_ready_q <= cfg_ready_d;
            running_q   <= running_d;
            current_q   <= current_d;
            sat_q       <= sat_d;
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign running   = running_q;
    assign current   = current_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_synapse_current.sv
// Self-checking bench for synapse_current: directed scenarios plus a randomized
// run, checked against an integer-arithmetic model of the weight/current rules.
module tb_synapse_current;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] spike_in = 8'h00;
    logic       post_spike = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [7:0] cfg_data = 8'h00;
    logic       cfg_last = 1'b0;
    logic       cfg_ready;
    logic [7:0] current;
    logic       sat;
    logic       running;

    int n_checks = 0;
    int n_fail   = 0;

    // model: 0 = idle, 1 = commit, 2 = run
    int m_state = 0;
    int m_cur = 0;
    bit m_sat = 1'b0;
    int w_sh [8];
    int w_act [8];

    synapse_current dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .spike_in   (spike_in),
        .post_spike (post_spike),
        .cfg_valid  (cfg_valid),
        .cfg_data   (cfg_data),
        .cfg_last   (cfg_last),
        .cfg_ready  (cfg_ready),
        .current    (current),
        .sat        (sat),
        .running    (running)
    );

    always #5 clk = ~clk;

    task automatic model_edge();
        bit accept;
        int s, n, wt;
        if (!rst_n) begin
            m_state = 0; m_cur = 0; m_sat = 1'b0;
            for (int i = 0; i < 8; i++) begin w_sh[i] = 0; w_act[i] = 0; end
        end else begin
            accept = cfg_valid && (m_state != 1);
            if (m_state != 0 && ena) begin
                s = 0;
                for (int i = 0; i < 8; i++) if (spike_in[i]) s += w_act[i];
                n = m_cur - m_cur / 8 + s;
`ifdef SYN_POSTSPIKE_RESET_EN
                if (post_spike) n = 0;
`endif
                m_sat = (n > 255);
                m_cur = (n < 0) ? 0 : (n > 255) ? 255 : n;
            end else if (m_state == 0) begin
                m_cur = 0; m_sat = 1'b0;
            end else begin
                m_sat = 1'b0;
            end
            if (m_state == 1) for (int i = 0; i < 8; i++) w_act[i] = w_sh[i];
            if (accept) begin
                wt = int'(cfg_data[3:0]);
                if (cfg_data[4]) wt = -wt;
                w_sh[int'(cfg_data[7:5])] = wt;
            end
            case (m_state)
                0: if (accept && cfg_last) m_state = 1;
                1: m_state = 2;
                default: if (accept && cfg_last) m_state = 1;
            endcase
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        n_checks += 4;
        if (current !== 8'd0)   begin n_fail++; $display("FAIL reset_current got %0d want 0", current); end
        if (sat !== 1'b0)       begin n_fail++; $display("FAIL reset_sat got %b want 0", sat); end
        if (running !== 1'b0)   begin n_fail++; $display("FAIL reset_running got %b want 0", running); end
        if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cfg_ready got %b want 1", cfg_ready); end
    endtask

    task automatic test_load_and_spike();
        cfg_valid = 1'b1; cfg_data = 8'h05; cfg_last = 1'b0; step();
        cfg_data = 8'h33; cfg_last = 1'b1; step();
        cfg_valid = 1'b0; cfg_last = 1'b0;
        n_checks += 2;
        if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL commit_cfg_ready got %b want 0", cfg_ready); end
        if (running !== 1'b1)   begin n_fail++; $display("FAIL commit_running got %b want 1", running); end
        step();
        n_checks++;
        if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL run_cfg_ready got %b want 1", cfg_ready); end
        spike_in = 8'h01; step(); spike_in = 8'h00;
        n_checks++;
        if (current !== 8'd5) begin n_fail++; $display("FAIL spike_w0 got %0d want 5", current); end
        step();
        n_checks++;
        if (current !== 8'd5) begin n_fail++; $display("FAIL hold_no_leak got %0d want 5", current); end
    endtask

    task automatic test_clamp_low();
        spike_in = 8'h02; step();
        n_checks++;
        if (current !== 8'd2) begin n_fail++; $display("FAIL inhib_1 got %0d want 2", current); end
        step(); spike_in = 8'h00;
        n_checks += 2;
        if (current !== 8'd0) begin n_fail++; $display("FAIL clamp_low got %0d want 0", current); end
        if (sat !== 1'b0)     begin n_fail++; $display("FAIL clamp_low_sat got %b want 0", sat); end
    endtask

    task automatic test_saturate();
        int exp_cur [4] = '{120, 225, 255, 255};
        bit exp_sat [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [2:0] a;
        for (int i = 0; i < 8; i++) begin
            a = 3'(i);
            cfg_valid = 1'b1; cfg_data = {a, 5'h0F}; cfg_last = (i == 7); step();
        end
        cfg_valid = 1'b0; cfg_last = 1'b0;
        step();
        spike_in = 8'hFF;
        for (int k = 0; k < 4; k++) begin
            step();
            n_checks += 2;
            if (current !== 8'(exp_cur[k])) begin n_fail++; $display("FAIL sat_seq_cur[%0d] got %0d want %0d", k, current, exp_cur[k]); end
            if (sat !== exp_sat[k])         begin n_fail++; $display("FAIL sat_seq_sat[%0d] got %b want %b", k, sat, exp_sat[k]); end
        end
        spike_in = 8'h00;
    endtask

    task automatic test_shadow_update();
        for (int k = 0; k < 12; k++) step();
        spike_in = 8'h01;
        cfg_valid = 1'b1; cfg_data = 8'h01; cfg_last = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            cfg_valid = 1'b0;
            n_checks += 2;
            if (current !== 8'(m_cur)) begin n_fail++; $display("FAIL shadow_traj[%0d] got %0d want %0d", k, current, m_cur); end
            if (cfg_ready !== 1'b1)    begin n_fail++; $display("FAIL shadow_ready[%0d] got %b want 1", k, cfg_ready); end
        end
        cfg_valid = 1'b1; cfg_data = 8'hE5; cfg_last = 1'b1; step();
        cfg_valid = 1'b0; cfg_last = 1'b0;
        n_checks += 2;
        if (cfg_ready !== 1'b0)    begin n_fail++; $display("FAIL last_ready got %b want 0", cfg_ready); end
        if (current !== 8'(m_cur)) begin n_fail++; $display("FAIL last_cur got %0d want %0d", current, m_cur); end
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks += 2;
            if (current !== 8'(m_cur)) begin n_fail++; $display("FAIL newbank_cur[%0d] got %0d want %0d", k, current, m_cur); end
            if (cfg_ready !== 1'b1)    begin n_fail++; $display("FAIL newbank_ready[%0d] got %b want 1", k, cfg_ready); end
        end
    endtask

    task automatic test_reset_mid();
        spike_in = 8'hFF;
        cfg_valid = 1'b1; cfg_data = 8'h2F; cfg_last = 1'b0; step();
        cfg_valid = 1'b0; rst_n = 1'b0; step(); rst_n = 1'b1;
        n_checks += 3;
        if (current !== 8'd0)   begin n_fail++; $display("FAIL midrst_cur got %0d want 0", current); end
        if (running !== 1'b0)   begin n_fail++; $display("FAIL midrst_running got %b want 0", running); end
        if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got %b want 1", cfg_ready); end
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (current !== 8'd0) begin n_fail++; $display("FAIL idle_ignore[%0d] got %0d want 0", k, current); end
        end
        cfg_valid = 1'b1; cfg_data = 8'h02; cfg_last = 1'b1; step();
        cfg_valid = 1'b0; cfg_last = 1'b0;
        step(); step();
        n_checks++;
        if (current !== 8'd2) begin n_fail++; $display("FAIL discard_partial got %0d want 2", current); end
    endtask

    task automatic test_postspike();
        post_spike = 1'b1; step(); post_spike = 1'b0;
        n_checks += 2;
`ifdef SYN_POSTSPIKE_RESET_EN
        if (current !== 8'd0) begin n_fail++; $display("FAIL postspike_clear got %0d want 0", current); end
`else
        if (current !== 8'd4) begin n_fail++; $display("FAIL postspike_ignored got %0d want 4", current); end
`endif
        if (sat !== 1'b0) begin n_fail++; $display("FAIL postspike_sat got %b want 0", sat); end
        spike_in = 8'h00;
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            rst_n      = ($urandom_range(0, 299) != 0);
            ena        = ($urandom_range(0, 7) != 0);
            spike_in   = 8'($urandom);
            cfg_valid  = ($urandom_range(0, 2) == 0);
            cfg_data   = 8'($urandom);
            cfg_last   = ($urandom_range(0, 6) == 0);
            post_spike = ($urandom_range(0, 9) == 0);
            step();
            n_checks += 4;
            if (current !== 8'(m_cur))   begin n_fail++; $display("FAIL rand_cur[%0d] got %0d want %0d", k, current, m_cur); end
            if (sat !== m_sat)           begin n_fail++; $display("FAIL rand_sat[%0d] got %b want %b", k, sat, m_sat); end
            if (running !== (m_state != 0))   begin n_fail++; $display("FAIL rand_running[%0d] got %b want %b", k, running, m_state != 0); end
            if (cfg_ready !== (m_state != 1)) begin n_fail++; $display("FAIL rand_ready[%0d] got %b want %b", k, cfg_ready, m_state != 1); end
        end
        rst_n = 1'b1; ena = 1'b1; cfg_valid = 1'b0; cfg_last = 1'b0;
        post_spike = 1'b0; spike_in = 8'h00;
    endtask

    initial begin
        test_reset();
        test_load_and_spike();
        test_clamp_low();
        test_saturate();
        test_shadow_update();
        test_reset_mid();
        test_postspike();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
